fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; direct upstream feeder of the decode-side double-op control unit.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_ras.sv | 51 +++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: PC-source encodings, NOP word and double-op opcodes.
// Optional feature macro FETCH_RAS_EN (return-address stack) is consumed by fetch_stage.
package fetch_stage_pkg;

    // Next-PC selection driven by the branch/jump resolution logic.
    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_RET    = 2'b11
    } pc_src_e;

    localparam int unsigned NOP_W = 32;
    localparam logic [NOP_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Double-op opcodes whose second half makes the control unit drop add_pc.
    localparam int unsigned OP_W = 6;
    localparam logic [OP_W-1:0] OP_LDW = 6'h23;
    localparam logic [OP_W-1:0] OP_SDW = 6'h2B;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_ras.sv
// return_addr_stack: circular return-address stack used by fetch_stage when
// FETCH_RAS_EN is defined; the whole file is empty otherwise.
// Ports: clk, reset (sync, active-high), push/push_data (CALL), pop (RET),
//        top (combinational value a RET redirects to).
// Full push overwrites the oldest entry; an empty pop leaves the stack unchanged
// and returns whatever sits at the pointer.
`ifdef FETCH_RAS_EN
module return_addr_stack #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;   // next free slot
    logic [CNT_W-1:0]  cnt_q;   // valid entries, saturates at DEPTH

    // Empty stack exposes the slot at the pointer (stale data) instead of the one below.
    assign top = (cnt_q == '0) ? mem_q[ptr_q] : mem_q[ptr_q - PTR_W'(1)];

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            mem_q[ptr_q] <= push_data;
            ptr_q        <= ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule : return_addr_stack
`endif

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC target mux and IF/ID pipeline register.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall              freeze PC, IF/ID and return stack
//   add_pc             0 = hold PC/IF/ID while a double-op second half is pending
//   pc_src, is_call    next-PC source; is_call turns JUMP into CALL
//   branch_target, jump_target, return_addr   redirect targets
//   imem_instr         instruction-memory read data for pc_out
//   pc_out             current fetch address
//   if_id_instr, if_id_pc1, if_id_valid       IF/ID register to decode
// Macro FETCH_RAS_EN: when defined, RET targets come from an internal
// return_addr_stack and return_addr is ignored; otherwise RET uses return_addr.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               add_pc,
    input  logic [1:0]         pc_src,
    input  logic               is_call,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic [ADDR_W-1:0]  return_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc1,
    output logic               if_id_valid
);

    if ((RAS_DEPTH == 0) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
        $error("fetch_stage: RAS_DEPTH must be a non-zero power of two");
    end

    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc1_q,   pc1_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  ret_target;
    logic [ADDR_W-1:0]  redirect_target;
    pc_src_e            src;

    assign src = pc_src_e'(pc_src);

`ifdef FETCH_RAS_EN
    logic ras_push;
    logic ras_pop;

    // Stack only moves on an unstalled CALL or RET; is_call is meaningless for other sources.
    assign ras_push = !stall && (src == PC_SRC_JUMP) && is_call;
    assign ras_pop  = !stall && (src == PC_SRC_RET);

    return_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc1_q),
        .top       (ret_target)
    );

    logic [ADDR_W-1:0] unused_return_addr;
    assign unused_return_addr = return_addr;
`else
    logic unused_is_call;
    assign unused_is_call = is_call;
    assign ret_target     = return_addr;
`endif

    // Redirect target selection.
    always_comb begin
        redirect_target = pc_q;
        unique case (src)
            PC_SRC_BRANCH: redirect_target = branch_target;
            PC_SRC_JUMP:   redirect_target = jump_target;
            PC_SRC_RET:    redirect_target = ret_target;
            default:       redirect_target = pc_q;
        endcase
    end

    // Next-state: stall > redirect > hold > sequential (reset handled in the register).
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        if (!stall) begin
            if (src != PC_SRC_SEQ) begin
                // Redirect squashes the wrong-path fetch into a bubble, even during a hold.
                pc_d    = redirect_target;
                instr_d = INSTR_W'(NOP_INSTR);
                pc1_d   = '0;
                valid_d = 1'b0;
            end else if (add_pc) begin
                pc_d    = pc_q + ADDR_W'(1);
                instr_d = imem_instr;
                pc1_d   = pc_q + ADDR_W'(1);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= INSTR_W'(NOP_INSTR);
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc1   = pc1_q;
    assign if_id_valid = valid_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stimulus process drives each cycle's inputs
// and pushes the architecturally expected fetch state; a monitor pops and compares
// after every rising edge. Follows FETCH_RAS_EN the same way as the design.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int RAS_D = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc1;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        add_pc;
    logic [1:0]  pc_src;
    logic        is_call;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] return_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc1;
    logic        if_id_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc1;
    logic        m_valid;
    logic [31:0] ras_mem [RAS_D];
    int          ras_ptr, ras_cnt;

    fetch_stage #(
        .ADDR_W    (32),
        .INSTR_W   (32),
        .RESET_PC  (32'h0),
        .RAS_DEPTH (RAS_D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .add_pc        (add_pc),
        .pc_src        (pc_src),
        .is_call       (is_call),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .return_addr   (return_addr),
        .imem_instr    (imem_instr),
        .pc_out        (pc_out),
        .if_id_instr   (if_id_instr),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr = imem_f(pc_out);

    // Architectural next state of the fetch stage for one clock edge.
    task automatic model_edge(input logic r, input logic st, input logic ap, input logic [1:0] src,
                              input logic call, input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] ra);
        logic [31:0] tgt;
        if (r) begin
            m_pc = 32'h0; m_instr = NOP_INSTR; m_pc1 = 32'h0; m_valid = 1'b0;
            for (int i = 0; i < RAS_D; i++) ras_mem[i] = 32'h0;
            ras_ptr = 0; ras_cnt = 0;
        end else if (st) begin
            // frozen
        end else if (src != 2'b00) begin
            tgt = (src == 2'b01) ? bt : jt;
`ifdef FETCH_RAS_EN
            if (src == 2'b10 && call) begin
                ras_mem[ras_ptr] = m_pc1;
                ras_ptr = (ras_ptr + 1) % RAS_D;
                if (ras_cnt < RAS_D) ras_cnt++;
            end
            if (src == 2'b11) begin
                if (ras_cnt > 0) begin
                    ras_ptr = (ras_ptr + RAS_D - 1) % RAS_D;
                    ras_cnt--;
                end
                tgt = ras_mem[ras_ptr];
            end
`else
            if (src == 2'b11) tgt = ra;
`endif
            m_pc = tgt; m_instr = NOP_INSTR; m_pc1 = 32'h0; m_valid = 1'b0;
        end else if (ap) begin
            m_instr = imem_f(m_pc);
            m_pc1   = m_pc + 32'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd1;
        end
    endtask

    // Drive one cycle of inputs and record the expected state after the next edge.
    task automatic step(input logic r, input logic st, input logic ap, input logic [1:0] src,
                        input logic call, input logic [31:0] bt, input logic [31:0] jt,
                        input logic [31:0] ra);
        @(negedge clk);
        reset = r; stall = st; add_pc = ap; pc_src = src; is_call = call;
        branch_target = bt; jump_target = jt; return_addr = ra;
        model_edge(r, st, ap, src, call, bt, jt, ra);
        exp_q.push_back('{pc: m_pc, instr: m_instr, pc1: m_pc1, valid: m_valid});
    endtask

    task automatic seq();
        step(0, 0, 1, 2'b00, 0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: compare DUT state against the scoreboard after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if ({pc_out, if_id_instr, if_id_pc1, if_id_valid} !== e) begin
                    bad++;
                    $display("FAIL fetch_state cyc=%0d got pc=%h instr=%h pc1=%h v=%b want pc=%h instr=%h pc1=%h v=%b",
                             cyc, pc_out, if_id_instr, if_id_pc1, if_id_valid,
                             e.pc, e.instr, e.pc1, e.valid);
                end
            end
        end
    end

    initial begin
        logic [1:0] src;
        reset = 1'b1; stall = 1'b0; add_pc = 1'b1; pc_src = 2'b00; is_call = 1'b0;
        branch_target = '0; jump_target = '0; return_addr = '0;

        // Reset, then first sequential fetch
        step(1, 0, 1, 2'b00, 0, 0, 0, 0);
        seq();
        // Double-op hold at PC=5
        step(0, 0, 1, 2'b10, 0, 0, 32'h5, 0);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0);
        seq();
        // Branch from PC=8 to 0x40, bubble then real fetch
        step(0, 0, 1, 2'b10, 0, 0, 32'h8, 0);
        step(0, 0, 1, 2'b01, 0, 32'h40, 0, 0);
        seq();
        // Stall masks a pending jump, which then takes effect; redirect beats hold
        step(0, 1, 1, 2'b10, 0, 0, 32'h80, 0);
        step(0, 1, 0, 2'b10, 0, 0, 32'h80, 0);
        step(0, 0, 0, 2'b10, 0, 0, 32'h80, 0);
        seq();
        // CALL with if_id_pc1=0x11, later RET
        step(0, 0, 1, 2'b10, 0, 0, 32'h10, 0);
        seq();
        step(0, 0, 1, 2'b10, 1, 0, 32'h30, 0);
        seq();
        step(0, 0, 1, 2'b11, 1, 0, 0, 32'h22);
        seq();
        // Five calls then five returns (overflow of the stack when present)
        for (int k = 1; k <= 5; k++) begin
            seq();
            step(0, 0, 1, 2'b10, 1, 0, 32'h100 * k, 0);
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 2'b11, 0, 0, 0, 32'h200 + k);
            seq();
        end
        // PC wrap at the top of the address space
        step(0, 0, 1, 2'b10, 0, 0, 32'hFFFF_FFFF, 0);
        seq();
        seq();
        // Reset during a hold wins
        step(0, 0, 1, 2'b10, 0, 0, 32'h77, 0);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0, 0, 0);
        seq();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            src = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) >= 20),
                 src,
                 1'($urandom_range(0, 1)),
                 $urandom(), $urandom(), $urandom());
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 8 && exp_q.size() != 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_stage
